// File: rtl/bloon_sprite_pkg.sv
// Shared types for the pop animation sprite: FSM state encoding, colour width, width helper.
// Pure declarations; no timing or flow control.
package bloon_sprite_pkg;

  localparam int COLOR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } anim_state_t;

  // Bit width needed to count 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pop_anim_rom.sv
// Synchronous sprite index ROM, one read per cycle, q valid 1 cycle after address.
// No backpressure: a new address is accepted every cycle.
module pop_anim_rom #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 1
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] address,
  output logic [IDX_W-1:0]  q
);

  // Stripe pattern taken from the low address bits,
  // so even columns are transparent and odd columns use palette entry 1.
  always_ff @(posedge clock) begin
    if (int'(address) < DEPTH) begin
      q <= IDX_W'(address);
    end else begin
      q <= '0;
    end
  end

endmodule

// File: rtl/pop_anim_sprite.sv
// Animated "pop" sprite: frame sequencer FSM plus ROM/palette pixel path, RGB 2 cycles after inputs.
// No backpressure: pixels stream every vga_clk; trigger restarts the animation at any time.
module pop_anim_sprite
  import bloon_sprite_pkg::*;
#(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 4,
  parameter int IDX_W           = 1,
  parameter int LOOP            = 0
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               frame_tick,
  input  logic [9:0]         RelativeXP,
  input  logic [9:0]         RelativeYP,
  input  logic               in_sprite,
  input  logic               blank,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               opaque,
  output logic               busy,
  output logic               done
);

  localparam int FRAME_PIX = SPRITE_W * SPRITE_H;
  localparam int DEPTH     = NUM_FRAMES * FRAME_PIX;
  localparam int ADDR_W    = width_of(DEPTH);
  localparam int FRAME_W   = width_of(NUM_FRAMES);
  localparam int TICK_W    = width_of(TICKS_PER_FRAME);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(TICKS_PER_FRAME - 1);

  anim_state_t        state, state_nxt;
  logic [FRAME_W-1:0] frame, frame_nxt;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;

  logic [ADDR_W-1:0]  rom_addr;
  logic [IDX_W-1:0]   rom_q;
  logic               in_box;
  logic               blank_d, in_box_d, active_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state    <= IDLE;
      frame    <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      frame    <= frame_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  // A trigger restarts from any state and beats a coincident frame advance.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame;
    tick_nxt  = tick_cnt;
    busy      = (state == PLAY);
    done      = (state == FINISH);
    if (trigger) begin
      state_nxt = PLAY;
      frame_nxt = '0;
      tick_nxt  = '0;
    end else begin
      case (state)
        PLAY: begin
          if (frame_tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_nxt = '0;
              if (frame == LAST_FRAME) begin
                if (LOOP != 0) frame_nxt = '0;
                else           state_nxt = FINISH;
              end else begin
                frame_nxt = frame + 1'b1;
              end
            end else begin
              tick_nxt = tick_cnt + 1'b1;
            end
          end
        end
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign rom_addr = ADDR_W'(frame) * ADDR_W'(FRAME_PIX)
                  + ADDR_W'(RelativeYP) * ADDR_W'(SPRITE_W)
                  + ADDR_W'(RelativeXP);

  // Out-of-box coordinates may alias into another frame's word, so mask them here.
  assign in_box = in_sprite
               && (RelativeXP < 10'(SPRITE_W))
               && (RelativeYP < 10'(SPRITE_H));

  pop_anim_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .clock   (vga_clk),
    .address (rom_addr),
    .q       (rom_q)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      blank_d  <= 1'b0;
      in_box_d <= 1'b0;
      active_d <= 1'b0;
    end else begin
      blank_d  <= blank;
      in_box_d <= in_box;
      active_d <= busy;
    end
  end

  function automatic logic [3*COLOR_W-1:0] palette(input logic [7:0] idx);
    case (idx)
      8'd1:    return 12'hF00;
      8'd2:    return 12'hFFF;
      8'd3:    return 12'hF80;
      default: return 12'hFF0;
    endcase
  endfunction

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      opaque <= 1'b0;
    end else if (blank_d && in_box_d && active_d && (rom_q != '0)) begin
      {red, green, blue} <= palette(8'(rom_q));
      opaque             <= 1'b1;
    end else begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      opaque <= 1'b0;
    end
  end

endmodule

// File: doc/pop_anim_sprite.md
POP_ANIM_SPRITE -- requirements
Module: pop_anim_sprite

Interface
REQ-001 SHALL have parameters (name, default, meaning): SPRITE_W 32, sprite width in pixels; SPRITE_H 32, sprite height in pixels; NUM_FRAMES 4, animation frames stored in ROM; TICKS_PER_FRAME 4, frame_tick pulses each frame is shown; IDX_W 1, palette index width; LOOP 0, 1 = wrap to frame 0 instead of finishing.
REQ-002 SHALL have ports (name, direction, width, meaning): vga_clk in 1 pixel clock; reset in 1 synchronous active-high reset; trigger in 1 start or restart animation; frame_tick in 1 one-cycle pulse per video frame; RelativeXP in 10 x within sprite box; RelativeYP in 10 y within sprite box; in_sprite in 1 current pixel lies inside the box; blank in 1 high = active video; red out 4; green out 4; blue out 4; opaque out 1 pixel is drawn and non-transparent; busy out 1 animation running; done out 1 one-cycle completion pulse.
REQ-003 SHALL use one clock (vga_clk) and a synchronous active-high reset (reset); there are no asynchronous paths.

Function
REQ-004 SHALL implement states IDLE, PLAY and FINISH.
REQ-005 IDLE: trigger -> PLAY, with frame=0 and tick_cnt=0.
REQ-006 PLAY: each frame_tick increments tick_cnt; on frame_tick with tick_cnt==TICKS_PER_FRAME-1, tick_cnt->0 and frame advances.
REQ-007 Advance from frame NUM_FRAMES-1: LOOP=1 -> frame 0, stay in PLAY; LOOP=0 -> FINISH, with frame held at NUM_FRAMES-1.
REQ-008 FINISH SHALL last exactly one cycle, assert done, then go to IDLE.
REQ-009 trigger in PLAY or FINISH SHALL restart: PLAY, frame=0, tick_cnt=0; trigger wins over a simultaneous frame_tick advance, and done is not asserted that cycle.
REQ-010 frame SHALL change only in cycles where frame_tick or trigger is high.
REQ-011 busy SHALL be 1 in PLAY and 0 in IDLE and FINISH.
REQ-012 ROM address SHALL be frame*SPRITE_W*SPRITE_H + RelativeYP*SPRITE_W + RelativeXP, computed at ADDR_W = clog2(NUM_FRAMES*SPRITE_W*SPRITE_H) bits, with products truncated to ADDR_W.
REQ-013 Pixel path latency SHALL be 2 cycles: inputs at cycle N, ROM q at N+1, registered RGB and opaque at N+2.
REQ-014 blank, in_sprite and the active flag (busy) SHALL be delayed 1 cycle to align with ROM q.
REQ-015 Output register: if delayed blank and in_sprite and active are all 1 and index!=0, red/green/blue = palette colour and opaque=1.
REQ-016 Otherwise red/green/blue=0 and opaque=0; index 0 is transparent.
REQ-017 RelativeXP>=SPRITE_W or RelativeYP>=SPRITE_H SHALL be treated as outside the sprite (opaque=0) regardless of in_sprite.

Reset
REQ-018 reset SHALL force state IDLE, frame=0, tick_cnt=0, the delay pipeline to 0, red/green/blue=0, opaque=0, busy=0, done=0 on the next vga_clk edge.
REQ-019 reset asserted mid-PLAY SHALL abort the animation without a done pulse; reset has priority over trigger.

Structure
REQ-020 Package bloon_sprite_pkg SHALL hold the anim_state_t enum and the colour-width constant (4).
REQ-021 Sub-module pop_anim_rom SHALL be a synchronous ROM (clock, address, q) of NUM_FRAMES*SPRITE_W*SPRITE_H x IDX_W.
REQ-022 The palette lookup SHALL be combinational inside pop_anim_sprite, with no further sub-modules.

Verification
REQ-023 Reset then trigger, 16 frame_tick pulses (defaults) -> frame sequence 0,0,0,0,1,...,3; done high exactly 1 cycle after the 16th pulse; busy low afterwards.
REQ-024 LOOP=1, 20 frame_tick pulses -> frame returns to 0 after the 16th pulse and reaches 1 after the 20th; done is never asserted.
REQ-025 Trigger on the same cycle as the 16th frame_tick -> state PLAY, frame 0, no done pulse.
REQ-026 PLAY, frame 2, RelativeXP=5, RelativeYP=3, blank=1, in_sprite=1 -> ROM address 2*1024+3*32+5=2149; RGB equals the palette entry of that word exactly 2 cycles later.
REQ-027 ROM word index 0, or blank=0, or RelativeXP=40 -> 2 cycles later red=green=blue=0 and opaque=0.
REQ-028 reset asserted at frame 1 of PLAY -> next cycle IDLE, busy=0, done=0, all outputs 0.
